// File: rtl/regfile_wb_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if : ALU and LSU writeback request channels
// Rev 1.0
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              alu_valid_i;
   logic [ADDR_W-1:0] alu_rd_i;
   logic [DATA_W-1:0] alu_data_i;
   logic              alu_ready_o;
   logic              lsu_valid_i;
   logic [ADDR_W-1:0] lsu_rd_i;
   logic [DATA_W-1:0] lsu_data_i;
   logic              lsu_ready_o;

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      output alu_ready_o,
      input  lsu_valid_i, lsu_rd_i, lsu_data_i,
      output lsu_ready_o
   );

   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      input  alu_ready_o,
      output lsu_valid_i, lsu_rd_i, lsu_data_i,
      input  lsu_ready_o
   );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_wb_arbiter : round-robin ALU/LSU writeback arbiter + load scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   regfile_wb_arbiter_if.slave wb,
   input  logic                rsv_en_i,
   input  logic [ADDR_W-1:0]   rsv_rd_i,
   input  logic [ADDR_W-1:0]   rs1_addr_i,
   input  logic [ADDR_W-1:0]   rs2_addr_i,
   output logic                rs1_busy_o,
   output logic                rs2_busy_o,
   output logic                reg_wr_en_o,
   output logic [ADDR_W-1:0]   rd_addr_o,
   output logic [DATA_W-1:0]   wr_data_o
);
   localparam int NREG = 2**ADDR_W;

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_LSU = 1'b1
   } grant_e;

   grant_e              last_grant_q, last_grant_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   rd_q, rd_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                src_lsu_q, src_lsu_d;
   logic [NREG-1:0]     busy_q, busy_d;

   logic alu_req, lsu_req, alu_x0, lsu_x0, alu_win, lsu_win, lsu_clr;

   // x0 requests are accepted outside arbitration and never write
   always_comb begin
      alu_x0  = wb.alu_valid_i && (wb.alu_rd_i == '0);
      lsu_x0  = wb.lsu_valid_i && (wb.lsu_rd_i == '0);
      alu_req = wb.alu_valid_i && (wb.alu_rd_i != '0);
      lsu_req = wb.lsu_valid_i && (wb.lsu_rd_i != '0);
      alu_win = alu_req && (!lsu_req || (last_grant_q == GRANT_LSU));
      lsu_win = lsu_req && (!alu_req || (last_grant_q == GRANT_ALU));
   end

   assign wb.alu_ready_o = alu_x0 || alu_win;
   assign wb.lsu_ready_o = lsu_x0 || lsu_win;

   assign lsu_clr = wr_en_q && src_lsu_q;

   always_comb begin
      last_grant_d = last_grant_q;
      wr_en_d      = 1'b0;
      rd_d         = rd_q;
      data_d       = data_q;
      src_lsu_d    = src_lsu_q;
      if (alu_win) begin
         last_grant_d = GRANT_ALU;
         wr_en_d      = 1'b1;
         rd_d         = wb.alu_rd_i;
         data_d       = wb.alu_data_i;
         src_lsu_d    = 1'b0;
      end else if (lsu_win) begin
         last_grant_d = GRANT_LSU;
         wr_en_d      = 1'b1;
         rd_d         = wb.lsu_rd_i;
         data_d       = wb.lsu_data_i;
         src_lsu_d    = 1'b1;
      end
   end

   // A new reservation overrides a clear landing on the same register
   always_comb begin
      busy_d    = '0;
      for (int i = 1; i < NREG; i++) begin
         busy_d[i] = (busy_q[i] && !(lsu_clr && (rd_q == ADDR_W'(i))))
                   || (rsv_en_i && (rsv_rd_i == ADDR_W'(i)));
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_grant_q <= GRANT_LSU;
         wr_en_q      <= 1'b0;
         rd_q         <= '0;
         data_q       <= '0;
         src_lsu_q    <= 1'b0;
         busy_q       <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         wr_en_q      <= wr_en_d;
         rd_q         <= rd_d;
         data_q       <= data_d;
         src_lsu_q    <= src_lsu_d;
         busy_q       <= busy_d;
      end
   end

   assign reg_wr_en_o = wr_en_q;
   assign rd_addr_o   = rd_q;
   assign wr_data_o   = data_q;
   assign rs1_busy_o  = busy_q[rs1_addr_i];
   assign rs2_busy_o  = busy_q[rs2_addr_i];
endmodule
`default_nettype wire
